// File: rtl/llr_pkg.sv
// llr_pkg: shared types and helpers for the LLR window buffer.
//   code_e    - code length select encoding (i_code)
//   state_e   - load/full state of the buffer
//   code_to_n - code select to code length N
//   sm_to_tc  - saturating sign-magnitude to two's complement conversion
package llr_pkg;

  typedef enum logic [1:0] {
    CODE_64   = 2'd0,
    CODE_256  = 2'd1,
    CODE_1024 = 2'd2,
    CODE_RSVD = 2'd3
  } code_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_FULL = 2'd2
  } state_e;

  // The reserved code decodes as the smallest length so that the read
  // window stays bounded while the buffer sits in IDLE after a bad start.
  function automatic logic [11:0] code_to_n(input code_e code);
    case (code)
      CODE_64:   code_to_n = 12'd64;
      CODE_256:  code_to_n = 12'd256;
      CODE_1024: code_to_n = 12'd1024;
      default:   code_to_n = 12'd64;
    endcase
  endfunction

  // Widths are passed as arguments so one helper serves any lane format.
  // Negating a zero magnitude yields zero, so -0 never reaches storage.
  function automatic logic [31:0] sm_to_tc(input logic [31:0] s,
                                           input int in_w,
                                           input int llr_w);
    logic [31:0] mag;
    logic [31:0] max_mag;
    mag     = s & ((32'd1 << (in_w - 1)) - 32'd1);
    max_mag = (32'd1 << (llr_w - 1)) - 32'd1;
    if (mag > max_mag) begin
      mag = max_mag;
    end else begin
      mag = mag;
    end
    if (s[in_w-1]) begin
      sm_to_tc = 32'd0 - mag;
    end else begin
      sm_to_tc = mag;
    end
  endfunction

endpackage

// File: rtl/llr_win_buf_sm_sat.sv
// llr_sm_sat: single-lane combinational sign-magnitude to saturated
// two's complement converter.
//   i_sample - IN_W-bit sign-magnitude sample (MSB = sign)
//   o_llr    - LLR_W-bit two's complement result
import llr_pkg::*;

module llr_sm_sat #(
  parameter int IN_W  = 8,
  parameter int LLR_W = 7
) (
  input  logic [IN_W-1:0]  i_sample,
  output logic [LLR_W-1:0] o_llr
);

  assign o_llr = LLR_W'(sm_to_tc(32'(i_sample), IN_W, LLR_W));

endmodule

// File: rtl/llr_win_buf.sv
// llr_win_buf: LLR staging buffer for the polar decoder front end.
// Loads a frame of N sign-magnitude LLRs (N = 64/256/1024) in LANES-wide
// beats, stores them saturated in two's complement, and exposes the first
// WIN entries through NRD read ports. The window rotates by WIN on request.
//   i_clk, i_rst          - clock, synchronous active-high reset
//   i_code, i_start       - code length select, frame start
//   i_valid, o_ready      - beat handshake; i_data carries LANES samples
//   i_rotate              - rotate the active region by WIN
//   i_pos, o_data         - per-port read index and read data
//   o_loaded, o_beat_cnt  - frame complete, beats accepted this frame
//   o_win_idx, o_err      - rotation count mod N/WIN, protocol error pulse
// Build option: define LLR_RD_REG_EN to register o_data (1-cycle latency).
import llr_pkg::*;

module llr_win_buf #(
  parameter int LLR_W = 7,
  parameter int IN_W  = 8,
  parameter int LANES = 8,
  parameter int N_MAX = 1024,
  parameter int WIN   = 128,
  parameter int NRD   = 4
) (
  input  logic                              i_clk,
  input  logic                              i_rst,
  input  logic [1:0]                        i_code,
  input  logic                              i_start,
  input  logic                              i_valid,
  output logic                              o_ready,
  input  logic [LANES*IN_W-1:0]             i_data,
  input  logic                              i_rotate,
  input  logic [NRD*$clog2(WIN)-1:0]        i_pos,
  output logic [NRD*LLR_W-1:0]              o_data,
  output logic                              o_loaded,
  output logic [$clog2(N_MAX/LANES):0]      o_beat_cnt,
  output logic [$clog2(N_MAX/WIN):0]        o_win_idx,
  output logic                              o_err
);

  localparam int AW  = $clog2(N_MAX);
  localparam int PW  = $clog2(WIN);
  localparam int LW  = $clog2(LANES);
  localparam int BCW = $clog2(N_MAX/LANES) + 1;
  localparam int WIW = $clog2(N_MAX/WIN) + 1;

  state_e             state_q, state_d;
  code_e              code_q, code_d;
  logic [BCW-1:0]     beat_q, beat_d;
  logic [WIW-1:0]     win_q, win_d;
  logic               err_q, err_d;
  logic               wr_s, rot_s;
  logic [AW:0]        n_s;
  logic [BCW-1:0]     bpf_s;
  logic [WIW-1:0]     wpf_s;
  logic [LLR_W-1:0]   lane_s [LANES];
  logic [LLR_W-1:0]   mem_q [N_MAX];
  logic [LLR_W-1:0]   mem_d [N_MAX];
  logic [NRD*LLR_W-1:0] rd_s;

  assign n_s   = (AW+1)'(code_to_n(code_q));
  assign bpf_s = BCW'(n_s >> LW);
  assign wpf_s = WIW'(n_s >> PW);

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    llr_sm_sat #(.IN_W(IN_W), .LLR_W(LLR_W)) u_sat (
      .i_sample (i_data[k*IN_W +: IN_W]),
      .o_llr    (lane_s[k])
    );
  end

  // Next-state, counters and protocol errors; a start overrides everything.
  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    beat_d  = beat_q;
    win_d   = win_q;
    err_d   = 1'b0;
    wr_s    = 1'b0;
    rot_s   = 1'b0;
    if (i_start) begin
      code_d = code_e'(i_code);
      beat_d = '0;
      win_d  = '0;
      if (code_e'(i_code) == CODE_RSVD) begin
        state_d = ST_IDLE;
        err_d   = 1'b1;
      end else begin
        state_d = ST_LOAD;
      end
    end else begin
      case (state_q)
        ST_LOAD: begin
          if (i_valid) begin
            wr_s   = 1'b1;
            beat_d = beat_q + BCW'(1);
            if (beat_d == bpf_s) begin
              state_d = ST_FULL;
            end else begin
              state_d = ST_LOAD;
            end
          end else begin
            wr_s = 1'b0;
          end
          err_d = i_rotate;
        end
        ST_FULL: begin
          if (i_rotate && (n_s > (AW+1)'(WIN))) begin
            rot_s = 1'b1;
            win_d = (win_q + WIW'(1) == wpf_s) ? '0 : win_q + WIW'(1);
            err_d = i_valid;
          end else begin
            err_d = i_valid | i_rotate;
          end
        end
        default: begin
          err_d = i_valid | i_rotate;
        end
      endcase
    end
  end

  // Memory next state: shift-in on a beat, rotate by WIN inside [0, N).
  always_comb begin
    mem_d = mem_q;
    if (wr_s) begin
      for (int i = 0; i < LANES; i++) begin
        mem_d[i] = lane_s[i];
      end
      for (int i = LANES; i < N_MAX; i++) begin
        if ((AW+1)'(i) < n_s) begin
          mem_d[i] = mem_q[i-LANES];
        end else begin
          mem_d[i] = mem_q[i];
        end
      end
    end else if (rot_s) begin
      for (int i = 0; i < N_MAX; i++) begin
        if ((AW+1)'(i) < n_s) begin
          // N is a power of two, so the wrap is a mask with N-1.
          mem_d[i] = mem_q[AW'(i + WIN) & AW'(n_s - (AW+1)'(1))];
        end else begin
          mem_d[i] = mem_q[i];
        end
      end
    end else begin
      mem_d = mem_q;
    end
  end

  // State, counters, error pulse and storage registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      code_q  <= CODE_64;
      beat_q  <= '0;
      win_q   <= '0;
      err_q   <= 1'b0;
      for (int i = 0; i < N_MAX; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      beat_q  <= beat_d;
      win_q   <= win_d;
      err_q   <= err_d;
      mem_q   <= mem_d;
    end
  end

  // Read ports. i_pos is always below WIN, so pos < min(N, WIN) reduces
  // to pos < N (only matters for N=64).
  always_comb begin
    rd_s = '0;
    for (int p = 0; p < NRD; p++) begin
      if ((AW+1)'(i_pos[p*PW +: PW]) < n_s) begin
        rd_s[p*LLR_W +: LLR_W] = mem_q[AW'(i_pos[p*PW +: PW])];
      end else begin
        rd_s[p*LLR_W +: LLR_W] = '0;
      end
    end
  end

`ifdef LLR_RD_REG_EN
  logic [NRD*LLR_W-1:0] rd_q;

  // Registered read data for the one-cycle-latency build.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rd_q <= '0;
    end else begin
      rd_q <= rd_s;
    end
  end

  assign o_data = rd_q;
`else
  assign o_data = rd_s;
`endif

  assign o_ready    = (state_q == ST_LOAD);
  assign o_loaded   = (state_q == ST_FULL);
  assign o_beat_cnt = beat_q;
  assign o_win_idx  = win_q;
  assign o_err      = err_q;

endmodule

// File: tb/tb_llr_win_buf.sv
// Scoreboard bench for llr_win_buf: the driver updates an array-based
// reference model each cycle and queues the expected outputs; a monitor
// pops and compares them shortly after every clock edge.
module tb_llr_win_buf;

  localparam int LLR_W = 7;
  localparam int IN_W  = 8;
  localparam int LANES = 8;
  localparam int N_MAX = 1024;
  localparam int WIN   = 128;
  localparam int NRD   = 4;
  localparam int PW    = $clog2(WIN);

  logic                         clk = 1'b0;
  logic                         i_rst = 1'b0;
  logic [1:0]                   i_code = 2'd0;
  logic                         i_start = 1'b0;
  logic                         i_valid = 1'b0;
  logic                         o_ready;
  logic [LANES*IN_W-1:0]        i_data = '0;
  logic                         i_rotate = 1'b0;
  logic [NRD*PW-1:0]            i_pos = '0;
  logic [NRD*LLR_W-1:0]         o_data;
  logic                         o_loaded;
  logic [$clog2(N_MAX/LANES):0] o_beat_cnt;
  logic [$clog2(N_MAX/WIN):0]   o_win_idx;
  logic                         o_err;

  llr_win_buf #(.LLR_W(LLR_W), .IN_W(IN_W), .LANES(LANES), .N_MAX(N_MAX),
                .WIN(WIN), .NRD(NRD)) dut (
    .i_clk(clk), .i_rst(i_rst), .i_code(i_code), .i_start(i_start),
    .i_valid(i_valid), .o_ready(o_ready), .i_data(i_data),
    .i_rotate(i_rotate), .i_pos(i_pos), .o_data(o_data),
    .o_loaded(o_loaded), .o_beat_cnt(o_beat_cnt), .o_win_idx(o_win_idx),
    .o_err(o_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NRD*LLR_W-1:0] data;
    bit ready, loaded, err;
    int beat, win;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;

  // Reference model: plain integer array plus frame bookkeeping.
  int model [N_MAX];
  int m_n = 64;
  bit m_load = 1'b0;
  bit m_full = 1'b0;
  int m_beats = 0;
  int m_win = 0;

  function automatic int n_of(input int c);
    if (c == 0) return 64;
    if (c == 1) return 256;
    if (c == 2) return 1024;
    return 64;
  endfunction

  // Sign-magnitude sample -> saturated value, returned as LLR_W-bit pattern.
  function automatic int conv(input int v);
    int sgn, mag, lim;
    sgn = (v >> (IN_W - 1)) & 1;
    mag = v & ((1 << (IN_W - 1)) - 1);
    lim = (1 << (LLR_W - 1)) - 1;
    if (mag > lim) mag = lim;
    if (sgn == 1) return (-mag) & ((1 << LLR_W) - 1);
    return mag;
  endfunction

  function automatic logic [NRD*LLR_W-1:0] read_all(input logic [NRD*PW-1:0] pos);
    logic [NRD*LLR_W-1:0] r;
    int q;
    r = '0;
    for (int p = 0; p < NRD; p++) begin
      q = int'(pos[p*PW +: PW]);
      if (q < m_n && q < WIN) r[p*LLR_W +: LLR_W] = LLR_W'(model[q]);
    end
    return r;
  endfunction

  function automatic logic [NRD*PW-1:0] rand_pos();
    logic [NRD*PW-1:0] r;
    for (int p = 0; p < NRD; p++) r[p*PW +: PW] = PW'($urandom_range(0, WIN - 1));
    return r;
  endfunction

  function automatic logic [LANES*IN_W-1:0] rand_data();
    logic [LANES*IN_W-1:0] r;
    for (int k = 0; k < LANES; k++) r[k*IN_W +: IN_W] = IN_W'($urandom);
    return r;
  endfunction

  // Drive one cycle of inputs, advance the model across the edge, queue expectation.
  task automatic cycle(input bit rst, input bit start, input int code,
                       input bit valid, input logic [LANES*IN_W-1:0] data,
                       input bit rot, input logic [NRD*PW-1:0] pos);
    exp_t e;
    int tmp [N_MAX];
    logic [NRD*LLR_W-1:0] pre_rd;
    bit was_load, was_full;
    @(negedge clk);
    i_rst = rst; i_start = start; i_code = 2'(code); i_valid = valid;
    i_data = data; i_rotate = rot; i_pos = pos;
    @(posedge clk);
    pre_rd = read_all(pos);
    was_load = m_load;
    was_full = m_full;
    e.err = 1'b0;
    if (rst) begin
      for (int i = 0; i < N_MAX; i++) model[i] = 0;
      m_n = 64; m_load = 0; m_full = 0; m_beats = 0; m_win = 0;
    end else if (start) begin
      m_n = n_of(code); m_beats = 0; m_win = 0; m_full = 0;
      m_load = (code != 3);
      e.err = (code == 3);
    end else begin
      if (valid) begin
        if (was_load) begin
          for (int i = m_n - 1; i >= LANES; i--) model[i] = model[i - LANES];
          for (int k = 0; k < LANES; k++) model[k] = conv(int'(data[k*IN_W +: IN_W]));
          m_beats++;
          if (m_beats == m_n / LANES) begin m_load = 0; m_full = 1; end
        end else e.err = 1'b1;
      end
      if (rot) begin
        if (was_full && m_n > WIN) begin
          for (int i = 0; i < N_MAX; i++) tmp[i] = model[i];
          for (int i = 0; i < m_n; i++) model[i] = tmp[(i + WIN) % m_n];
          m_win = (m_win + 1) % (m_n / WIN);
        end else e.err = 1'b1;
      end
    end
    e.ready = m_load; e.loaded = m_full; e.beat = m_beats; e.win = m_win;
`ifdef LLR_RD_REG_EN
    e.data = rst ? '0 : pre_rd;
`else
    e.data = read_all(pos);
`endif
    exp_q.push_back(e);
  endtask

  task automatic idle();
    cycle(1'b0, 1'b0, 0, 1'b0, '0, 1'b0, rand_pos());
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h at %0t", name, act, expv, $time);
    end
  endtask

  // Monitor: compare DUT outputs against the queued expectation each cycle.
  always begin
    exp_t e;
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("data",     64'(o_data),     64'(e.data));
      chk("ready",    64'(o_ready),    64'(e.ready));
      chk("loaded",   64'(o_loaded),   64'(e.loaded));
      chk("err",      64'(o_err),      64'(e.err));
      chk("beat_cnt", 64'(o_beat_cnt), 64'(e.beat));
      chk("win_idx",  64'(o_win_idx),  64'(e.win));
    end
  end

  initial begin
    logic [LANES*IN_W-1:0] d;
    logic [NRD*PW-1:0] pos;
    int sent;
    for (int i = 0; i < N_MAX; i++) model[i] = 0;

    cycle(1'b1, 1'b0, 0, 1'b0, '0, 1'b0, '0);
    cycle(1'b1, 1'b0, 0, 1'b0, '0, 1'b0, rand_pos());

    // Code 0 load with counting pattern; port0=63, port1=0, port2=7, port3=100 (out of N).
    pos = '0;
    pos[0*PW +: PW] = PW'(63); pos[1*PW +: PW] = PW'(0);
    pos[2*PW +: PW] = PW'(7);  pos[3*PW +: PW] = PW'(100);
    cycle(1'b0, 1'b1, 0, 1'b0, '0, 1'b0, pos);
    for (int b = 0; b < 8; b++) begin
      for (int k = 0; k < LANES; k++) d[k*IN_W +: IN_W] = IN_W'(b * 8 + k);
      cycle(1'b0, 1'b0, 0, 1'b1, d, 1'b0, pos);
    end
    cycle(1'b0, 1'b0, 0, 1'b0, '0, 1'b0, pos);
    cycle(1'b0, 1'b0, 0, 1'b0, '0, 1'b0, pos);

    // Rotate and a beat while FULL with N <= WIN: both rejected.
    cycle(1'b0, 1'b0, 0, 1'b0, '0, 1'b1, pos);
    cycle(1'b0, 1'b0, 0, 1'b1, rand_data(), 1'b0, pos);
    idle();

    // Saturation: last beat of a code-0 frame carries the corner values.
    cycle(1'b0, 1'b1, 0, 1'b0, '0, 1'b0, rand_pos());
    for (int b = 0; b < 7; b++) cycle(1'b0, 1'b0, 0, 1'b1, rand_data(), 1'b0, rand_pos());
    d = {8'h81, 8'h40, 8'h3F, 8'hC0, 8'h05, 8'h7F, 8'h80, 8'hFF};
    cycle(1'b0, 1'b0, 0, 1'b1, d, 1'b0, rand_pos());
    for (int g = 0; g < 2; g++) begin
      for (int p = 0; p < NRD; p++) pos[p*PW +: PW] = PW'(g * NRD + p);
      cycle(1'b0, 1'b0, 0, 1'b0, '0, 1'b0, pos);
    end
    idle();

    // Code 2: 128 beats with random gaps, then 8 rotations.
    cycle(1'b0, 1'b1, 2, 1'b0, '0, 1'b0, rand_pos());
    sent = 0;
    while (sent < 128) begin
      if ($urandom_range(0, 3) != 0) begin
        cycle(1'b0, 1'b0, 0, 1'b1, rand_data(), 1'b0, rand_pos());
        sent++;
      end else idle();
    end
    idle();
    for (int r = 0; r < 8; r++) begin
      cycle(1'b0, 1'b0, 0, 1'b0, '0, 1'b1, rand_pos());
      if ($urandom_range(0, 1) == 1) idle();
    end
    idle();

    // Code 1: restart with a colliding beat mid-load, then reset mid-load.
    cycle(1'b0, 1'b1, 1, 1'b0, '0, 1'b0, rand_pos());
    for (int b = 0; b < 5; b++) cycle(1'b0, 1'b0, 0, 1'b1, rand_data(), 1'b0, rand_pos());
    cycle(1'b0, 1'b1, 1, 1'b1, rand_data(), 1'b0, rand_pos());
    for (int b = 0; b < 3; b++) cycle(1'b0, 1'b0, 0, 1'b1, rand_data(), 1'b0, rand_pos());
    cycle(1'b1, 1'b0, 0, 1'b1, rand_data(), 1'b1, rand_pos());
    idle();
    idle();

    // Reserved code, then stray handshake/rotate in IDLE.
    cycle(1'b0, 1'b1, 3, 1'b0, '0, 1'b0, rand_pos());
    cycle(1'b0, 1'b0, 0, 1'b1, rand_data(), 1'b0, rand_pos());
    cycle(1'b0, 1'b0, 0, 1'b0, '0, 1'b1, rand_pos());

    // Random soak.
    for (int c = 0; c < 600; c++) begin
      cycle(($urandom_range(0, 299) == 0), ($urandom_range(0, 149) == 0),
            int'($urandom_range(0, 3)), ($urandom_range(0, 9) < 7), rand_data(),
            ($urandom_range(0, 9) == 0), rand_pos());
    end
    idle();
    idle();

    @(posedge clk);
    #3;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d expected=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
